// File: rtl/vtc_gen.sv
// Video timing generator: free-running H/V counters producing sync, DE and frame-start.
// Latency: all outputs registered, 1 cycle behind the internal counters.
// Backpressure: none; EN_I is sampled only at frame boundaries, so a frame always completes.
//
// Ports:
//   CLK_I, RST_I (async, active-high), EN_I (run request)
//   VS_O, HS_O, DE_O : C_PORT_NUM-wide copies of vsync / hsync / data enable
//   H_CNT_O, V_CNT_O : counter values that produced the current DE_O
//   FS_O             : one-cycle pulse on the first cycle of line 0
module vtc_gen #(
  parameter int C_PORT_NUM = 4,
  parameter int H_ACTIVE   = 480,
  parameter int H_FP       = 22,
  parameter int H_SYNC     = 11,
  parameter int H_BP       = 37,
  parameter int V_ACTIVE   = 1080,
  parameter int V_FP       = 4,
  parameter int V_SYNC     = 5,
  parameter int V_BP       = 36,
  parameter int HS_POL     = 1,
  parameter int VS_POL     = 1
) (
  input  logic                  CLK_I,
  input  logic                  RST_I,
  input  logic                  EN_I,
  output logic [C_PORT_NUM-1:0] VS_O,
  output logic [C_PORT_NUM-1:0] HS_O,
  output logic [C_PORT_NUM-1:0] DE_O,
  output logic [15:0]           H_CNT_O,
  output logic [15:0]           V_CNT_O,
  output logic                  FS_O
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [15:0] H_LAST       = 16'(H_TOTAL - 1);
  localparam logic [15:0] V_LAST       = 16'(V_TOTAL - 1);
  localparam logic [15:0] H_ACT_END    = 16'(H_ACTIVE);
  localparam logic [15:0] V_ACT_END    = 16'(V_ACTIVE);
  localparam logic [15:0] H_SYNC_START = 16'(H_ACTIVE + H_FP);
  localparam logic [15:0] H_SYNC_END   = 16'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [15:0] V_SYNC_START = 16'(V_ACTIVE + V_FP);
  localparam logic [15:0] V_SYNC_END   = 16'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic HS_ACT = (HS_POL != 0);
  localparam logic VS_ACT = (VS_POL != 0);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state;
  logic [15:0] hcnt;
  logic [15:0] vcnt;

  logic h_end, v_end;
  logic de_act, hs_act, vs_act;

  always_comb begin
    h_end  = (hcnt == H_LAST);
    v_end  = (vcnt == V_LAST);
    de_act = (hcnt < H_ACT_END) && (vcnt < V_ACT_END);
    hs_act = (hcnt >= H_SYNC_START) && (hcnt < H_SYNC_END);
    // Vertical sync spans whole lines, so its edges fall on hcnt=0.
    vs_act = (vcnt >= V_SYNC_START) && (vcnt < V_SYNC_END);
  end

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      state   <= IDLE;
      hcnt    <= '0;
      vcnt    <= '0;
      DE_O    <= '0;
      HS_O    <= {C_PORT_NUM{~HS_ACT}};
      VS_O    <= {C_PORT_NUM{~VS_ACT}};
      FS_O    <= 1'b0;
      H_CNT_O <= '0;
      V_CNT_O <= '0;
    end else begin
      case (state)
        IDLE: begin
          hcnt    <= '0;
          vcnt    <= '0;
          DE_O    <= '0;
          HS_O    <= {C_PORT_NUM{~HS_ACT}};
          VS_O    <= {C_PORT_NUM{~VS_ACT}};
          FS_O    <= 1'b0;
          H_CNT_O <= '0;
          V_CNT_O <= '0;
          if (EN_I) state <= RUN;
        end
        RUN: begin
          // Outputs reflect the counters as they stand before this edge.
          DE_O    <= {C_PORT_NUM{de_act}};
          HS_O    <= {C_PORT_NUM{hs_act == HS_ACT}};
          VS_O    <= {C_PORT_NUM{vs_act == VS_ACT}};
          FS_O    <= (hcnt == '0) && (vcnt == '0);
          H_CNT_O <= hcnt;
          V_CNT_O <= vcnt;
          if (h_end) begin
            hcnt <= '0;
            if (v_end) begin
              vcnt <= '0;
              // Frame boundary: the only place EN_I can stop the generator.
              if (!EN_I) state <= IDLE;
            end else begin
              vcnt <= vcnt + 16'd1;
            end
          end else begin
            hcnt <= hcnt + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vtc_gen.sv
// Bench for vtc_gen with a small 14x7 timing: two instances (active-high and
// active-low sync) share stimulus; outputs are compared each cycle with a model
// that tracks a flat position within the frame, plus per-phase event counts.
module tb_vtc_gen;

  localparam int HA = 8, HF = 2, HS = 2, HB = 2;
  localparam int VA = 4, VF = 1, VS = 1, VB = 1;
  localparam int HT = HA + HF + HS + HB;   // 14
  localparam int VT = VA + VF + VS + VB;   // 7
  localparam int FT = HT * VT;             // 98

  logic        clk, rst, en;
  logic [3:0]  vs_o, hs_o, de_o;
  logic [15:0] hc_o, vc_o;
  logic        fs_o;
  logic [3:0]  vs_n, hs_n, de_n;
  logic [15:0] hc_n, vc_n;
  logic        fs_n;

  vtc_gen #(
    .C_PORT_NUM(4), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .HS_POL(1), .VS_POL(1)
  ) dut (
    .CLK_I(clk), .RST_I(rst), .EN_I(en),
    .VS_O(vs_o), .HS_O(hs_o), .DE_O(de_o),
    .H_CNT_O(hc_o), .V_CNT_O(vc_o), .FS_O(fs_o)
  );

  vtc_gen #(
    .C_PORT_NUM(4), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .HS_POL(0), .VS_POL(0)
  ) dut_n (
    .CLK_I(clk), .RST_I(rst), .EN_I(en),
    .VS_O(vs_n), .HS_O(hs_n), .DE_O(de_n),
    .H_CNT_O(hc_n), .V_CNT_O(vc_n), .FS_O(fs_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference: running flag plus position within the frame (0..FT-1).
  int          m_run = 0;
  int          m_pos = 0;
  logic [3:0]  e_vs, e_hs, e_de;
  logic        e_fs;
  logic [15:0] e_h, e_v;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Expected outputs after the coming edge, then advance the model across it.
  task automatic model_step(input logic r, input logic e);
    int h, v;
    if (!r && m_run != 0) begin
      h    = m_pos % HT;
      v    = m_pos / HT;
      e_de = {4{(h < HA) && (v < VA)}};
      e_hs = {4{(h >= HA + HF) && (h < HA + HF + HS)}};
      e_vs = {4{(v >= VA + VF) && (v < VA + VF + VS)}};
      e_fs = (m_pos == 0);
      e_h  = 16'(h);
      e_v  = 16'(v);
    end else begin
      e_de = '0; e_hs = '0; e_vs = '0; e_fs = 1'b0; e_h = '0; e_v = '0;
    end
    if (r) begin
      m_run = 0; m_pos = 0;
    end else if (m_run == 0) begin
      m_run = e ? 1 : 0; m_pos = 0;
    end else if (m_pos == FT - 1) begin
      m_pos = 0; m_run = e ? 1 : 0;
    end else begin
      m_pos++;
    end
  endtask

  task automatic compare_outputs(input string tag);
    check({tag, "_pos"}, 64'({vs_o, hs_o, de_o, fs_o, hc_o, vc_o}),
                         64'({e_vs, e_hs, e_de, e_fs, e_h, e_v}));
    check({tag, "_neg"}, 64'({vs_n, hs_n, de_n, fs_n, hc_n, vc_n}),
                         64'({~e_vs, ~e_hs, e_de, e_fs, e_h, e_v}));
  endtask

  // Called at a negedge; returns at the following negedge.
  task automatic step(input logic r, input logic e);
    rst = r;
    en  = e;
    model_step(r, e);
    @(posedge clk);
    @(negedge clk);
    compare_outputs("cyc");
  endtask

  typedef struct {
    logic rst;
    logic en;
    logic rnd;
    int   cycles;
    int   fs, de, vs, hs;   // expected event counts over the phase, -1 = skip
  } phase_t;

  phase_t ph[7];

  initial begin
    int c_fs, c_de, c_vs, c_hs;
    logic e;

    // Reset with EN high, then RUN on first edge after release.
    ph[0] = '{1'b1, 1'b1, 1'b0, 3,   0,  0,  0,  0};
    // Idle edge + two full frames.
    ph[1] = '{1'b0, 1'b1, 1'b0, 197, 2,  64, 28, 28};
    // Start of third frame up to line 2, hcnt 1.
    ph[2] = '{1'b0, 1'b1, 1'b0, 30,  1,  18, 0,  4};
    // EN dropped mid-frame: frame completes, then idle.
    ph[3] = '{1'b0, 1'b0, 1'b0, 78,  0,  14, 14, 10};
    // Randomised EN, model-checked only.
    ph[4] = '{1'b0, 1'b0, 1'b1, 400, -1, -1, -1, -1};
    ph[5] = '{1'b1, 1'b0, 1'b0, 2,   0,  0,  0,  0};
    // Runs up to line 1, hcnt 5 (counter value, outputs one behind).
    ph[6] = '{1'b0, 1'b1, 1'b0, 20,  1,  13, 0,  2};

    rst = 1'b1;
    en  = 1'b0;
    #1;
    e_de = '0; e_hs = '0; e_vs = '0; e_fs = 1'b0; e_h = '0; e_v = '0;
    compare_outputs("reset");
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      c_fs = 0; c_de = 0; c_vs = 0; c_hs = 0;
      for (int k = 0; k < ph[i].cycles; k++) begin
        e = ph[i].rnd ? ($urandom_range(0, 3) != 0) : ph[i].en;
        step(ph[i].rst, e);
        c_fs += int'(fs_o);
        c_de += int'(de_o[0]);
        c_vs += int'(vs_o[0]);
        c_hs += int'(hs_o[0]);
      end
      if (ph[i].fs >= 0) begin
        check($sformatf("ph%0d_fs", i), 64'(c_fs), 64'(ph[i].fs));
        check($sformatf("ph%0d_de", i), 64'(c_de), 64'(ph[i].de));
        check($sformatf("ph%0d_vs", i), 64'(c_vs), 64'(ph[i].vs));
        check($sformatf("ph%0d_hs", i), 64'(c_hs), 64'(ph[i].hs));
      end
    end

    // Mid-frame async reset: outputs must clear without waiting for an edge.
    check("pre_rst_vcnt", 64'(vc_o), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    e_de = '0; e_hs = '0; e_vs = '0; e_fs = 1'b0; e_h = '0; e_v = '0;
    compare_outputs("async_rst");
    m_run = 0;
    m_pos = 0;
    @(negedge clk);
    step(1'b1, 1'b0);

    // Released with EN low: stays idle, no frame start.
    c_fs = 0;
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 1'b0);
      c_fs += int'(fs_o);
    end
    check("no_fs_after_rst", 64'(c_fs), 64'd0);

    // EN raised: one idle output cycle, then frame start.
    step(1'b0, 1'b1);
    check("restart_idle_fs", 64'(fs_o), 64'd0);
    step(1'b0, 1'b1);
    check("restart_fs", 64'(fs_o), 64'd1);
    for (int k = 0; k < 20; k++) step(1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
